// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the instruction memory of the single-cycle MIPS
// core. It consumes a byte stream (valid/ready) laid out as
//     LEN_LO, LEN_HI, 4*N data bytes, CHK
// It assembles each group of four data bytes into a little-endian 32-bit word
// and writes the word into instruction memory. CHK must equal the XOR of every
// byte before it. The core is held in reset until a full image has been stored
// and the checksum matches.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        synchronous active-low reset
//   start          begin a load (honoured only in IDLE, DONE or ERROR)
//   in_valid       in_data carries a byte
//   in_data        stream byte
//   in_ready       loader takes in_data this cycle (transfer = valid && ready)
//   mem_we         one-cycle write strobe per assembled word
//   mem_addr       byte address of the word being written (word_index*4)
//   mem_write_data assembled word
//   mem_data_size  access size, always word (2'b10)
//   cpu_reset_n    active-low reset to the core, released only after success
//   busy           load in progress
//   done           last load succeeded (held until the next start)
//   error          last load failed (held until the next start)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_data_size,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int DEPTH_WORDS = 1 << (ADDR_WIDTH - 2);
    // One extra bit so the index can reach DEPTH_WORDS after the last write.
    localparam int IDX_W = ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      len_reg;
    logic [7:0]       xor_reg;
    logic [31:0]      word_reg;
    logic [1:0]       byte_count_reg;
    logic [IDX_W-1:0] word_index_reg;

    logic             in_ready_reg;
    logic             mem_we_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_write_data_reg;
    logic             cpu_reset_n_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;

    logic             accept;
    logic [15:0]      len_full;
    logic [31:0]      word_full;
    logic [16:0]      index_inc;

    assign accept    = in_valid && in_ready_reg;
    assign len_full  = {in_data, len_reg[7:0]};
    // Bytes enter at the top and shift down, so after four bytes the first
    // one received sits in [7:0].
    assign word_full = {in_data, word_reg[31:8]};
    assign index_inc = 17'(word_index_reg) + 17'd1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERROR: if (start) state_next = LEN0;
            LEN0:              if (accept) state_next = LEN1;
            LEN1: begin
                if (accept) begin
                    if (17'(len_full) > 17'(DEPTH_WORDS))
                        state_next = ERROR;
                    else if (len_full == 16'd0)
                        state_next = CHECK;
                    else
                        state_next = DATA;
                end
            end
            DATA:  if (accept && byte_count_reg == 2'd3) state_next = WRITE;
            WRITE: state_next = (index_inc == {1'b0, len_reg}) ? CHECK : DATA;
            CHECK: if (accept) state_next = (in_data == xor_reg) ? DONE : ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            len_reg            <= '0;
            xor_reg            <= '0;
            word_reg           <= '0;
            byte_count_reg     <= '0;
            word_index_reg     <= '0;
            in_ready_reg       <= 1'b0;
            mem_we_reg         <= 1'b0;
            mem_addr_reg       <= '0;
            mem_write_data_reg <= '0;
            cpu_reset_n_reg    <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            error_reg          <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Status outputs are decoded from the next state so they line up
            // with the state register on the same edge.
            in_ready_reg    <= state_next inside {LEN0, LEN1, DATA, CHECK};
            busy_reg        <= state_next inside {LEN0, LEN1, DATA, WRITE, CHECK};
            done_reg        <= (state_next == DONE);
            error_reg       <= (state_next == ERROR);
            cpu_reset_n_reg <= (state_next == DONE);

            mem_we_reg <= 1'b0;

            // Running checksum over every accepted byte; the CHK byte itself
            // also folds in, which is harmless because the load ends there.
            if (accept) xor_reg <= xor_reg ^ in_data;

            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        word_index_reg <= '0;
                        byte_count_reg <= '0;
                        xor_reg        <= '0;
                    end
                end
                LEN0: if (accept) len_reg <= {8'h00, in_data};
                LEN1: if (accept) len_reg <= len_full;
                DATA: begin
                    if (accept) begin
                        word_reg       <= word_full;
                        byte_count_reg <= byte_count_reg + 2'd1;
                        // Present the write on the WRITE cycle itself; the
                        // address/data registers then hold until the next word.
                        if (byte_count_reg == 2'd3) begin
                            mem_we_reg         <= 1'b1;
                            mem_addr_reg       <= {{(32 - ADDR_WIDTH){1'b0}},
                                                   word_index_reg[IDX_W-2:0], 2'b00};
                            mem_write_data_reg <= word_full;
                        end
                    end
                end
                WRITE: word_index_reg <= word_index_reg + IDX_W'(1);
                default: ;
            endcase
        end
    end

    assign in_ready       = in_ready_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_write_data = mem_write_data_reg;
    assign mem_data_size  = 2'b10;
    assign cpu_reset_n    = cpu_reset_n_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign error          = error_reg;

endmodule
